// File: rtl/psum_drain_arbiter_pkg.sv
// Shared sizes, FIFO entry layout and the rounding/saturation helper for the psum drain path.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package psum_drain_arbiter_pkg;

    // Default configuration of the collector
    localparam int NUM_CH_DEF     = 3;
    localparam int PSUM_W_DEF     = 10;
    localparam int OUT_W_DEF      = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int SHIFT_W_DEF    = 3;
    localparam int CHAN_W_DEF     = (NUM_CH_DEF > 1) ? $clog2(NUM_CH_DEF) : 1;

    // The helper works at a fixed wide width so one function serves every
    // parametrisation: psums up to 32 bits plus one guard bit for the rounding add.
    localparam int CALC_W      = 33;
    localparam int SHIFT_MAX_W = 5;

    // FIFO entry layout for the default configuration
    typedef struct packed {
        logic [CHAN_W_DEF-1:0] chan;
        logic [OUT_W_DEF-1:0]  data;
    } fifo_entry_t;

    // Result of sat_round: scaled value (low bits are the output word) and a clamp flag.
    // ovf sits in the LSB so a caller can size-cast to OUT_W+1 bits and get {data, ovf}.
    typedef struct packed {
        logic [CALC_W-1:0] data;
        logic              ovf;
    } sat_res_t;

    // Round-half-up arithmetic right shift, then clamp to a signed out_w range when
    // sat_en is set; otherwise the caller keeps only the low out_w bits.
    function automatic sat_res_t sat_round(
        input logic signed [CALC_W-1:0]      x,
        input logic        [SHIFT_MAX_W-1:0] shift,
        input logic                          sat_en,
        input int                            out_w
    );
        logic signed [CALC_W-1:0] r;
        logic signed [CALC_W-1:0] max_pos;
        logic signed [CALC_W-1:0] min_neg;
        sat_res_t                 res;
        if (shift == '0) begin
            r = x;
        end else begin
            r = (x + $signed(CALC_W'(1) << (shift - 1'b1))) >>> shift;
        end
        max_pos  = $signed((CALC_W'(1) << (out_w - 1)) - CALC_W'(1));
        min_neg  = ~max_pos;
        res.data = r;
        res.ovf  = 1'b0;
        if (sat_en) begin
            if (r > max_pos) begin
                res.data = max_pos;
                res.ovf  = 1'b1;
            end else if (r < min_neg) begin
                res.data = min_neg;
                res.ovf  = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/psum_drain_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the priority pointer.
// Latency: grant is combinational from req; pointer moves on the edge where advance is high.
// Backpressure: pointer holds while advance is low, so a stalled winner keeps its priority.
module psum_drain_arbiter_rr_arbiter #(
    parameter int NUM_CH = 3,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_advance,
    output logic [NUM_CH-1:0] o_grant,
    output logic [IDX_W-1:0]  o_grant_idx
);

    logic [IDX_W-1:0] r_rr;
    logic             w_found;

    // Scan channels starting at the pointer, wrapping modulo NUM_CH; first requester wins
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_found && i_req[(int'(r_rr) + i) % NUM_CH]) begin
                w_found                                = 1'b1;
                o_grant[(int'(r_rr) + i) % NUM_CH]     = 1'b1;
                o_grant_idx                            = IDX_W'((int'(r_rr) + i) % NUM_CH);
            end
        end
    end

    // Priority moves to the channel after the one just served
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_rr <= '0;
        end else if (i_advance) begin
            r_rr <= (o_grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : o_grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/psum_drain_arbiter.sv
// Collects psums from NUM_CH channels round-robin, round-shifts/saturates, queues {chan,data}.
// Latency: accept at edge N is on write_o after edge N when the FIFO was empty; 1 result/cycle.
// Backpressure: ready drops only when the FIFO is full; ready never looks at write_ready_i.
module psum_drain_arbiter
    import psum_drain_arbiter_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int PSUM_W     = PSUM_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int SHIFT_W    = SHIFT_W_DEF,
    parameter int CHAN_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic [NUM_CH*PSUM_W-1:0] psum_i,
    input  logic [NUM_CH-1:0]        psum_valid_i,
    output logic [NUM_CH-1:0]        psum_ready_o,
    input  logic [SHIFT_W-1:0]       shift_i,
    input  logic                     sat_en_i,
    output logic [OUT_W-1:0]         write_o,
    output logic [CHAN_W-1:0]        chan_o,
    output logic                     write_valid_o,
    input  logic                     write_ready_i,
    output logic [15:0]              ovf_count_o,
    input  logic                     clear_ovf_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [CHAN_W-1:0] chan;
        logic [OUT_W-1:0]  data;
    } entry_t;

    logic [NUM_CH-1:0]        w_grant;
    logic [CHAN_W-1:0]        w_grant_idx;
    logic [NUM_CH-1:0]        w_ready;
    logic                     w_full;
    logic                     w_push;
    logic                     w_pop;
    logic signed [PSUM_W-1:0] w_sel_psum;
    logic [OUT_W-1:0]         w_sc_data;
    logic                     w_sc_ovf;

    entry_t                   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_head;
    logic [PTR_W-1:0]         r_tail;
    logic [PTR_W:0]           r_count;
    logic [15:0]              r_ovf_count;

    psum_drain_arbiter_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CHAN_W)
    ) u_rr_arbiter (
        .i_clk       (clk),
        .i_nrst      (nRST),
        .i_req       (psum_valid_i),
        .i_advance   (w_push),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // Ready is the grant qualified by space in the FIFO; held low while reset is asserted.
    // A pop in the same cycle does not reopen a full FIFO, keeping write_ready_i off this path.
    assign w_full       = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign w_ready      = (nRST && !w_full) ? w_grant : '0;
    assign psum_ready_o = w_ready;
    assign w_push       = |(psum_valid_i & w_ready);
    assign w_pop        = (r_count != '0) && write_ready_i;

    // Scale the granted channel's psum; shift/sat controls only matter on the accept edge
    assign w_sel_psum = psum_i[w_grant_idx * PSUM_W +: PSUM_W];
    assign {w_sc_data, w_sc_ovf} = (OUT_W + 1)'(sat_round(CALC_W'(w_sel_psum),
                                                          SHIFT_MAX_W'(shift_i),
                                                          sat_en_i, OUT_W));

    // Circular-buffer pointers and occupancy; reset drops everything buffered
    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy gates what is visible
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= '{chan: w_grant_idx, data: w_sc_data};
        end
    end

    // Clamp-event counter: sticks at all-ones, clear takes priority over a same-cycle clamp
    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_ovf_count <= '0;
        end else if (clear_ovf_i) begin
            r_ovf_count <= '0;
        end else if (w_push && w_sc_ovf && (r_ovf_count != 16'hFFFF)) begin
            r_ovf_count <= r_ovf_count + 16'd1;
        end
    end

    assign write_valid_o = (r_count != '0);
    assign write_o       = write_valid_o ? r_mem[r_head].data : '0;
    assign chan_o        = write_valid_o ? r_mem[r_head].chan : '0;
    assign ovf_count_o   = r_ovf_count;

endmodule

// File: tb/tb_psum_drain_arbiter.sv
// Self-checking bench for psum_drain_arbiter: directed scenarios plus a randomized run.
// Latency: reference model is queue-based and advances once per clock edge.
// Backpressure: write_ready_i is driven both held and randomized.
module tb_psum_drain_arbiter;
    import psum_drain_arbiter_pkg::*;

    localparam int NCH   = 3;
    localparam int PW    = 10;
    localparam int OW    = 8;
    localparam int DEPTH = 4;
    localparam int SW    = 3;

    logic              clk = 1'b0;
    logic              nrst;
    logic [NCH*PW-1:0] psum;
    logic [NCH-1:0]    vld;
    logic [NCH-1:0]    rdy;
    logic [SW-1:0]     shift;
    logic              sat_en;
    logic [OW-1:0]     wdata;
    logic [1:0]        chan;
    logic              wvld;
    logic              wrdy;
    logic [15:0]       ovf;
    logic              clr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: queue of pending outputs, priority pointer, clamp counter
    fifo_entry_t m_q[$];
    int          m_rr  = 0;
    int          m_ovf = 0;

    psum_drain_arbiter #(
        .NUM_CH(NCH), .PSUM_W(PW), .OUT_W(OW), .FIFO_DEPTH(DEPTH), .SHIFT_W(SW)
    ) dut (
        .clk(clk), .nRST(nrst), .psum_i(psum), .psum_valid_i(vld), .psum_ready_o(rdy),
        .shift_i(shift), .sat_en_i(sat_en), .write_o(wdata), .chan_o(chan),
        .write_valid_o(wvld), .write_ready_i(wrdy), .ovf_count_o(ovf), .clear_ovf_i(clr)
    );

    always #5 clk = ~clk;

    // floor((x + 2^(s-1)) / 2^s), i.e. round half up
    function automatic int m_scale(int x, int s);
        int n, d, q;
        if (s == 0) return x;
        n = x + (1 << (s - 1));
        d = 1 << s;
        q = n / d;
        if ((n % d) != 0 && n < 0) q = q - 1;
        return q;
    endfunction

    function automatic int m_grant();
        for (int i = 0; i < NCH; i++) begin
            if (vld[(m_rr + i) % NCH]) return (m_rr + i) % NCH;
        end
        return -1;
    endfunction

    function automatic logic [NCH-1:0] m_ready();
        int g;
        if (!nrst || m_q.size() >= DEPTH) return '0;
        g = m_grant();
        if (g < 0) return '0;
        return NCH'(1 << g);
    endfunction

    function automatic logic [7:0] m_hd();
        return (m_q.size() != 0) ? m_q[0].data : 8'h00;
    endfunction

    function automatic logic [1:0] m_hc();
        return (m_q.size() != 0) ? m_q[0].chan : 2'd0;
    endfunction

    task automatic set_psum(int ch, int val);
        psum[ch*PW +: PW] = PW'(val);
    endtask

    // Advance the model with the inputs currently applied, then clock the DUT
    task automatic step();
        int g, x, q;
        bit ov, full;
        fifo_entry_t e;
        if (!nrst) begin
            m_q.delete();
            m_rr  = 0;
            m_ovf = 0;
        end else begin
            full = (m_q.size() >= DEPTH);
            g    = m_grant();
            ov   = 1'b0;
            if (m_q.size() > 0 && wrdy) m_q.delete(0);
            if (!full && g >= 0) begin
                x = $signed(psum[g*PW +: PW]);
                q = m_scale(x, int'(shift));
                if (sat_en && q > 127) begin
                    q = 127; ov = 1'b1;
                end else if (sat_en && q < -128) begin
                    q = -128; ov = 1'b1;
                end
                e.chan = 2'(g);
                e.data = 8'(q);
                m_q.push_back(e);
                m_rr = (g + 1) % NCH;
            end
            if (clr) m_ovf = 0;
            else if (ov && m_ovf < 65535) m_ovf = m_ovf + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(int ch, int val);
        vld = '0;
        vld[ch] = 1'b1;
        set_psum(ch, val);
        step();
        vld = '0;
    endtask

    task automatic test_reset();
        nrst = 1'b0; vld = '1; wrdy = 1'b0; clr = 1'b0; shift = '0; sat_en = 1'b1; psum = '0;
        step();
        step();
        n_tests++; if (rdy !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b want 000", rdy); end
        n_tests++; if (wvld !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", wvld); end
        n_tests++; if (wdata !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", wdata); end
        n_tests++; if (chan !== 2'd0) begin n_fail++; $display("FAIL reset_chan: got %0d want 0", chan); end
        n_tests++; if (ovf !== 16'd0) begin n_fail++; $display("FAIL reset_ovf: got %0d want 0", ovf); end
        nrst = 1'b1; vld = '0; wrdy = 1'b1;
        #1;
    endtask

    task automatic test_saturate();
        shift = 3'd0; sat_en = 1'b1; wrdy = 1'b1;
        vld = 3'b001; set_psum(0, 300);
        #1;
        n_tests++; if (rdy !== 3'b001) begin n_fail++; $display("FAIL sat_ready: got %b want 001", rdy); end
        step();
        vld = '0;
        n_tests++; if (wvld !== 1'b1) begin n_fail++; $display("FAIL sat_latency: got %b want 1", wvld); end
        n_tests++; if (wdata !== 8'h7F) begin n_fail++; $display("FAIL sat_pos: got %h want 7f", wdata); end
        n_tests++; if (chan !== 2'd0) begin n_fail++; $display("FAIL sat_chan: got %0d want 0", chan); end
        n_tests++; if (ovf !== 16'd1) begin n_fail++; $display("FAIL sat_ovf1: got %0d want 1", ovf); end
        send(0, -300);
        n_tests++; if (wdata !== 8'h80) begin n_fail++; $display("FAIL sat_neg: got %h want 80", wdata); end
        n_tests++; if (ovf !== 16'd2) begin n_fail++; $display("FAIL sat_ovf2: got %0d want 2", ovf); end
    endtask

    task automatic test_round();
        int         vals[3] = '{6, -6, 5};
        logic [7:0] exps[3] = '{8'h02, 8'hFF, 8'h01};
        shift = 3'd2; sat_en = 1'b1; wrdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(1, vals[i]);
            n_tests++; if (wdata !== exps[i]) begin n_fail++; $display("FAIL round_%0d: got %h want %h", i, wdata, exps[i]); end
            n_tests++; if (chan !== 2'd1) begin n_fail++; $display("FAIL round_chan_%0d: got %0d want 1", i, chan); end
        end
        n_tests++; if (ovf !== 16'd2) begin n_fail++; $display("FAIL round_ovf: got %0d want 2", ovf); end
    endtask

    task automatic test_truncate();
        shift = 3'd0; sat_en = 1'b1; wrdy = 1'b1; clr = 1'b1;
        send(2, 300);
        clr = 1'b0;
        n_tests++; if (ovf !== 16'd0) begin n_fail++; $display("FAIL clear_wins: got %0d want 0", ovf); end
        n_tests++; if (wdata !== 8'h7F) begin n_fail++; $display("FAIL clear_data: got %h want 7f", wdata); end
        sat_en = 1'b0;
        send(2, 300);
        n_tests++; if (wdata !== 8'h2C) begin n_fail++; $display("FAIL trunc_pos: got %h want 2c", wdata); end
        n_tests++; if (ovf !== 16'd0) begin n_fail++; $display("FAIL trunc_ovf: got %0d want 0", ovf); end
        send(2, -300);
        n_tests++; if (wdata !== 8'hD4) begin n_fail++; $display("FAIL trunc_neg: got %h want d4", wdata); end
        sat_en = 1'b1;
    endtask

    task automatic test_round_robin();
        wrdy = 1'b1; vld = 3'b111; shift = 3'd0;
        set_psum(0, 10); set_psum(1, 20); set_psum(2, 30);
        for (int i = 0; i < 6; i++) begin
            #1;
            n_tests++; if (rdy !== NCH'(1 << (i % 3))) begin n_fail++; $display("FAIL rr_ready_%0d: got %b want %b", i, rdy, NCH'(1 << (i % 3))); end
            step();
            n_tests++; if (chan !== 2'(i % 3)) begin n_fail++; $display("FAIL rr_chan_%0d: got %0d want %0d", i, chan, i % 3); end
            n_tests++; if (wdata !== m_hd()) begin n_fail++; $display("FAIL rr_data_%0d: got %h want %h", i, wdata, m_hd()); end
        end
        vld = '0;
        step();
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        wrdy = 1'b0; vld = 3'b001; shift = 3'd0; sat_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_psum(0, 10 * i + 1);
            #1;
            if (rdy[0]) acc++;
            n_tests++; if (rdy !== m_ready()) begin n_fail++; $display("FAIL bp_ready_%0d: got %b want %b", i, rdy, m_ready()); end
            step();
        end
        n_tests++; if (acc !== 4) begin n_fail++; $display("FAIL bp_accepts: got %0d want 4", acc); end
        wrdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_psum(0, 100 + i);
            #1;
            if (i == 0) begin
                n_tests++; if (rdy !== 3'b000) begin n_fail++; $display("FAIL bp_full_pop: got %b want 000", rdy); end
            end
            if (i == 1) begin
                n_tests++; if (rdy !== 3'b001) begin n_fail++; $display("FAIL bp_reopen: got %b want 001", rdy); end
            end
            if (i < 4) begin
                n_tests++; if (wdata !== 8'(10 * i + 1)) begin n_fail++; $display("FAIL bp_order_%0d: got %h want %h", i, wdata, 8'(10 * i + 1)); end
            end
            n_tests++; if (wdata !== m_hd()) begin n_fail++; $display("FAIL bp_model_%0d: got %h want %h", i, wdata, m_hd()); end
            step();
        end
        vld = '0;
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_reset_midstream();
        wrdy = 1'b0; sat_en = 1'b1; shift = 3'd0;
        send(0, 300);
        send(0, 300);
        n_tests++; if (ovf !== 16'(m_ovf)) begin n_fail++; $display("FAIL mid_ovf_pre: got %0d want %0d", ovf, m_ovf); end
        nrst = 1'b0; vld = 3'b001;
        #1;
        n_tests++; if (rdy !== 3'b000) begin n_fail++; $display("FAIL mid_ready_rst: got %b want 000", rdy); end
        step();
        nrst = 1'b1; vld = '0;
        n_tests++; if (wvld !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", wvld); end
        n_tests++; if (ovf !== 16'd0) begin n_fail++; $display("FAIL mid_ovf: got %0d want 0", ovf); end
        vld = 3'b100; set_psum(2, 7);
        #1;
        n_tests++; if (rdy !== 3'b100) begin n_fail++; $display("FAIL mid_grant: got %b want 100", rdy); end
        step();
        vld = '0;
        n_tests++; if (wvld !== 1'b1 || chan !== 2'd2 || wdata !== 8'h07) begin
            n_fail++; $display("FAIL mid_first: got v=%b c=%0d d=%h want v=1 c=2 d=07", wvld, chan, wdata);
        end
        wrdy = 1'b1;
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            vld    = NCH'($urandom);
            for (int k = 0; k < NCH; k++) psum[k*PW +: PW] = PW'($urandom_range(0, 1023));
            shift  = SW'($urandom_range(0, 7));
            sat_en = 1'($urandom);
            wrdy   = ($urandom_range(0, 3) != 0);
            clr    = ($urandom_range(0, 31) == 0);
            nrst   = ($urandom_range(0, 63) != 0);
            #1;
            n_tests++; if (rdy !== m_ready()) begin n_fail++; $display("FAIL rnd_ready_%0d: got %b want %b", c, rdy, m_ready()); end
            n_tests++; if (wvld !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid_%0d: got %b want %b", c, wvld, m_q.size() != 0); end
            n_tests++; if (wdata !== m_hd()) begin n_fail++; $display("FAIL rnd_data_%0d: got %h want %h", c, wdata, m_hd()); end
            n_tests++; if (chan !== m_hc()) begin n_fail++; $display("FAIL rnd_chan_%0d: got %0d want %0d", c, chan, m_hc()); end
            n_tests++; if (ovf !== 16'(m_ovf)) begin n_fail++; $display("FAIL rnd_ovf_%0d: got %0d want %0d", c, ovf, m_ovf); end
            step();
        end
        vld = '0; clr = 1'b0; nrst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_saturate();
        test_round();
        test_truncate();
        test_round_robin();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
